// File: rtl/fpga_config_loader.sv
// rtl/fpga_config_loader.sv - serial bitstream loader for a logic-cell array
// Checks a sync byte, then writes one 18-bit frame (mux_sync, mux_carry, LUT) per cell.
module fpga_config_loader #(
  parameter int         N_CELLS   = 8,
  parameter int         IDX_W     = $clog2(N_CELLS),
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic               bs_valid_i,
  input  logic               bs_data_i,
  output logic               bs_ready_o,
  output logic [15:0]        config_lut_o,
  output logic [N_CELLS-1:0] config_lut_we_o,
  output logic [N_CELLS-1:0] mux_sync_o,
  output logic [N_CELLS-1:0] mux_carry_o,
  output logic               cfg_active_o,
  output logic               done_o,
  output logic               error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  logic [17:0]        r_shift;
  logic [4:0]         r_bit_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_ready;
  logic [15:0]        r_lut;
  logic [N_CELLS-1:0] r_we;
  logic [N_CELLS-1:0] r_mux_sync;
  logic [N_CELLS-1:0] r_mux_carry;
  logic               r_active;
  logic               r_done;
  logic               r_error;

  logic               w_accept;
  logic [17:0]        w_shift_next;
  logic               w_last_cell;
  logic [N_CELLS-1:0] w_onehot;

  assign w_accept     = bs_valid_i & r_ready;
  assign w_shift_next = {r_shift[16:0], bs_data_i};
  assign w_last_cell  = (r_idx == IDX_W'(N_CELLS - 1));
  assign w_onehot     = N_CELLS'(1) << r_idx;

  assign bs_ready_o      = r_ready;
  assign config_lut_o    = r_lut;
  assign config_lut_we_o = r_we;
  assign mux_sync_o      = r_mux_sync;
  assign mux_carry_o     = r_mux_carry;
  assign cfg_active_o    = r_active;
  assign done_o          = r_done;
  assign error_o         = r_error;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_idx       <= '0;
      r_ready     <= 1'b0;
      r_lut       <= '0;
      r_we        <= '0;
      r_mux_sync  <= '0;
      r_mux_carry <= '0;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // The write enable is a single-cycle pulse; only the LOAD exit raises it.
      r_we <= '0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            r_state   <= S_SYNC;
            r_ready   <= 1'b1;
            r_active  <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_bit_cnt <= '0;
            r_idx     <= '0;
          end
        end
        S_SYNC: begin
          if (w_accept) begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt <= '0;
              if (w_shift_next[7:0] == SYNC_WORD) begin
                r_state <= S_LOAD;
              end else begin
                r_state  <= S_ERR;
                r_ready  <= 1'b0;
                r_active <= 1'b0;
                r_error  <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == 5'd17) begin
              r_bit_cnt          <= '0;
              r_lut              <= w_shift_next[15:0];
              r_we               <= w_onehot;
              r_mux_sync[r_idx]  <= w_shift_next[17];
              r_mux_carry[r_idx] <= w_shift_next[16];
              r_ready            <= 1'b0;
              r_state            <= S_WRITE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
        end
        S_WRITE: begin
          if (w_last_cell) begin
            r_state  <= S_DONE;
            r_active <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_ready <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_ready  <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// tb/tb_fpga_config_loader.sv - directed bench for fpga_config_loader
// Linear directed steps with hand-computed expectations, N_CELLS = 8.
module tb_fpga_config_loader;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       bs_valid;
  logic       bs_data;
  logic       bs_ready;
  logic [15:0] config_lut;
  logic [7:0] config_lut_we;
  logic [7:0] mux_sync;
  logic [7:0] mux_carry;
  logic       cfg_active;
  logic       done;
  logic       error;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int we_cnt = 0;
  int c0 = 0;
  int we_snap = 0;

  fpga_config_loader #(
    .N_CELLS  (8),
    .SYNC_WORD(8'hA5)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .start_i        (start),
    .bs_valid_i     (bs_valid),
    .bs_data_i      (bs_data),
    .bs_ready_o     (bs_ready),
    .config_lut_o   (config_lut),
    .config_lut_we_o(config_lut_we),
    .mux_sync_o     (mux_sync),
    .mux_carry_o    (mux_carry),
    .cfg_active_o   (cfg_active),
    .done_o         (done),
    .error_o        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (|config_lut_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit gap);
    int n;
    if (gap && ($urandom_range(0, 1) == 1)) begin
      bs_valid = 1'b0;
      @(negedge clk);
    end
    bs_valid = 1'b1;
    bs_data  = b;
    n = 0;
    while (!bs_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, bs_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

  task automatic send_frame(input logic [17:0] f, input bit gap);
    for (int i = 17; i >= 0; i--) send_bit(f[i], gap);
  endtask

  task automatic check_write(input int idx, input logic [15:0] lut);
    logic [7:0] exp_we;
    exp_we = 8'd1 << idx;
    chk($sformatf("we_pulse%0d", idx), {24'd0, config_lut_we}, {24'd0, exp_we});
    chk($sformatf("lut%0d", idx), {16'd0, config_lut}, {16'd0, lut});
    @(negedge clk);
    chk($sformatf("we_clear%0d", idx), {24'd0, config_lut_we}, 32'd0);
  endtask

  task automatic do_start();
    bs_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    chk("start_active", {31'd0, cfg_active}, 32'd1);
    chk("start_ready", {31'd0, bs_ready}, 32'd1);
    chk("start_done_clr", {31'd0, done}, 32'd0);
    chk("start_err_clr", {31'd0, error}, 32'd0);
  endtask

  task automatic full_config(input bit pattern);
    logic [17:0] f;
    logic [15:0] lut;
    send_byte(8'hA5);
    for (int i = 0; i < 8; i++) begin
      lut = pattern ? (16'h5A00 + 16'(i)) : (16'h1000 + 16'(i));
      f   = pattern ? {(i % 2 == 1), (i % 2 == 0), lut} : {2'b11, lut};
      send_frame(f, 1'b0);
      check_write(i, lut);
    end
    chk("done_level", {31'd0, done}, 32'd1);
    chk("done_cycle", 32'(cyc - c0), 32'd160);
    chk("done_inactive", {31'd0, cfg_active}, 32'd0);
    chk("done_ready", {31'd0, bs_ready}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    bs_valid = 1'b0;
    bs_data  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lut", {16'd0, config_lut}, 32'd0);
    chk("rst_we", {24'd0, config_lut_we}, 32'd0);
    chk("rst_sync", {24'd0, mux_sync}, 32'd0);
    chk("rst_carry", {24'd0, mux_carry}, 32'd0);
    chk("rst_ready", {31'd0, bs_ready}, 32'd0);
    chk("rst_flags", {29'd0, cfg_active, done, error}, 32'd0);
    reset_n = 1'b1;

    // IDLE ignores valid bits
    bs_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", {31'd0, bs_ready}, 32'd0);
    chk("idle_active", {31'd0, cfg_active}, 32'd0);

    do_start();
    full_config(1'b0);
    chk("full_sync", {24'd0, mux_sync}, 32'hFF);
    chk("full_carry", {24'd0, mux_carry}, 32'hFF);

    // trailing bits after DONE are not consumed
    we_snap = we_cnt;
    bs_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_done_ready", {31'd0, bs_ready}, 32'd0);
    chk("post_done_level", {31'd0, done}, 32'd1);
    chk("post_done_no_we", 32'(we_cnt - we_snap), 32'd0);

    // reconfigure: gappy frame 0, start pulse inside frame 1, partial frame 2
    do_start();
    send_byte(8'hA5);
    send_frame(18'h2_BEEF, 1'b1);
    check_write(0, 16'hBEEF);
    chk("gap_sync", {24'd0, mux_sync}, 32'hFF);
    chk("gap_carry", {24'd0, mux_carry}, 32'hFE);
    for (int i = 17; i >= 0; i--) begin
      start = (i == 9);
      send_bit(logic'((18'h1_1234 >> i) & 18'd1), 1'b0);
    end
    start = 1'b0;
    check_write(1, 16'h1234);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
    chk("partial_sync", {24'd0, mux_sync}, 32'hFD);
    chk("partial_carry", {24'd0, mux_carry}, 32'hFE);
    chk("partial_active", {31'd0, cfg_active}, 32'd1);
    chk("partial_done", {31'd0, done}, 32'd0);
    chk("partial_lut", {16'd0, config_lut}, 32'h1234);

    // asynchronous reset mid-load of cell 2
    we_snap = we_cnt;
    reset_n = 1'b0;
    #1;
    chk("arst_lut", {16'd0, config_lut}, 32'd0);
    chk("arst_sync", {24'd0, mux_sync}, 32'd0);
    chk("arst_carry", {24'd0, mux_carry}, 32'd0);
    chk("arst_flags", {28'd0, bs_ready, cfg_active, done, error}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bs_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_no_we", 32'(we_cnt - we_snap), 32'd0);
    chk("arst_idle", {30'd0, bs_ready, cfg_active}, 32'd0);

    // bad sync byte
    do_start();
    we_snap = we_cnt;
    send_byte(8'hA4);
    chk("err_level", {31'd0, error}, 32'd1);
    chk("err_ready", {31'd0, bs_ready}, 32'd0);
    chk("err_active", {31'd0, cfg_active}, 32'd0);
    bs_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_no_we", 32'(we_cnt - we_snap), 32'd0);
    chk("err_hold", {31'd0, error}, 32'd1);

    // recovery after error
    do_start();
    full_config(1'b1);
    chk("rec_sync", {24'd0, mux_sync}, 32'hAA);
    chk("rec_carry", {24'd0, mux_carry}, 32'h55);
    chk("rec_error", {31'd0, error}, 32'd0);
    bs_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fpga_config_loader.md
Name: fpga_config_loader

Overview:
- Serial configuration controller for an array of N_CELLS logic cells.
- Accepts a bitstream over a valid/ready serial port and checks an 8-bit sync word.
- Assembles one 18-bit frame per cell, then writes the LUT word with a one-cycle per-cell write-enable and latches the cell's static mux controls (sync/async select, carry-in select).
- Sits between the external configuration port and the logic-cell array. It also holds the array's flip-flop enables low while configuration is in progress.

Parameters:
- N_CELLS, 8, number of logic cells configured; 2..64.
- IDX_W, $clog2(N_CELLS), width of the cell index counter.
- SYNC_WORD, 8'hA5, required header preceding cell frames.

Ports:
- clk_i  input  1  clock
- reset_ni  input  1  asynchronous reset, active low
- start_i  input  1  begin configuration; sampled in IDLE, DONE or ERR only
- bs_valid_i  input  1  bitstream bit valid
- bs_data_i  input  1  bitstream bit, MSB first
- bs_ready_o  output  1  loader accepts a bit this cycle
- config_lut_o  output  16  LUT word broadcast to all cells
- config_lut_we_o  output  N_CELLS  one-hot LUT write enable
- mux_sync_o  output  N_CELLS  per-cell sync/async mux select (registered)
- mux_carry_o  output  N_CELLS  per-cell carry-in mux select (registered)
- cfg_active_o  output  1  high while configuring; gates the array's dffe inputs low
- done_o  output  1  configuration complete (level)
- error_o  output  1  sync word mismatch (level)

Behaviour:
- Reset (async, reset_ni=0):
  - State is IDLE.
  - All outputs are 0: config_lut_o=16'h0000, config_lut_we_o=0, mux_sync_o=0, mux_carry_o=0, bs_ready_o=0, cfg_active_o=0, done_o=0, error_o=0.
  - Bit and cell counters clear.
  - Reset mid-load abandons the load with no partial write.
- Handshake: a bit is accepted on a rising edge with bs_valid_i & bs_ready_o. bs_valid_i low stalls the loader indefinitely with no timeout.
- States:
  - IDLE: bs_ready_o=0. start_i=1 -> SYNC; clears done_o and error_o and resets the counters.
  - SYNC: bs_ready_o=1. Shifts 8 accepted bits.
    - On the 8th accepted bit: if the assembled byte == SYNC_WORD -> LOAD, else -> ERR.
  - LOAD: bs_ready_o=1. Shifts accepted bits into an 18-bit frame register.
    - Frame bit 17 = mux_sync, bit 16 = mux_carry, bits 15..0 = LUT config.
    - On the edge accepting the 18th bit:
      - config_lut_o <= frame[15:0].
      - config_lut_we_o <= one-hot(idx).
      - mux_sync_o[idx] and mux_carry_o[idx] are updated.
      - Next state is WRITE.
  - WRITE: exactly one cycle; bs_ready_o=0; config_lut_we_o is one-hot during this cycle only.
    - Exit: if idx==N_CELLS-1 -> DONE, else idx++ -> LOAD.
    - config_lut_we_o is 0 again from the next cycle.
  - DONE: done_o=1, bs_ready_o=0. start_i=1 -> SYNC (reconfiguration).
  - ERR: error_o=1, bs_ready_o=0. No writes occur. start_i=1 -> SYNC.
- Output timing and hold:
  - cfg_active_o=1 in SYNC, LOAD and WRITE.
  - config_lut_o holds its last value outside writes.
  - mux_*_o bits of cells not yet rewritten keep their previous values during reconfiguration.
- Timing:
  - Minimum configuration length = 8 + 19*N_CELLS cycles from the first SYNC cycle to entering DONE.
  - The WRITE cycle is a mandatory 1-bit bubble per cell.
- start_i in SYNC, LOAD or WRITE is ignored.
- bs_valid_i while bs_ready_o=0 is ignored; no bit is consumed.
- Bits arriving after the final frame are not consumed, because bs_ready_o=0 in DONE.

Test Plan:
- Reset during LOAD of cell 2 (N_CELLS=8) -> all outputs 0 on the reset edge, asynchronously. After release, state is IDLE and no we pulse occurs.
- start_i, sync 0xA5, then 8 frames each 18'h3_xxxx with LUT word 16'h1000+idx, bits sent continuously -> config_lut_we_o pulses 0x01, 0x02 .. 0x80, one cycle each, with config_lut_o = 16'h1000+idx at each pulse. Final mux_sync_o = mux_carry_o = 8'hFF. done_o rises at cycle 8+19*8=160.
- Sync byte 0xA4 -> error_o=1 the cycle after the 8th bit; bs_ready_o=0; no we pulses. start_i then a valid stream -> normal completion with error_o cleared.
- Random bs_valid_i gaps (50% duty) during frame 0 = 18'h2_BEEF -> single we pulse with config_lut_o=16'hBEEF, mux_sync_o[0]=1, mux_carry_o[0]=0. Bit count unaffected by gaps.
- start_i asserted during LOAD -> ignored; frame sequence unchanged.
- After DONE, reconfigure with frame 0 only partially sent -> mux_*_o[7:1] keep their old values, cfg_active_o=1, done_o=0.
